// File: rtl/ysyx_25020047_lsu_if.sv
// Decode/memory/writeback signal bundle for the load/store unit.
// Valid/ready: a transfer happens on a rising clk edge where valid and ready are both high; once raised, valid and its payload stay stable until that edge.
interface ysyx_25020047_lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_imm;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_imm,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    input  out_ready,
    output in_ready,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output out_valid, out_rdata, out_err
  );

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_imm,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    output out_ready,
    input  in_ready,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  out_valid, out_rdata, out_err
  );
endinterface

// File: rtl/ysyx_25020047_lsu.sv
// Single-outstanding load/store unit: lw, lbu, sw, sb with misalignment check
// and a response watchdog; every output except in_ready is registered.
module ysyx_25020047_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_25020047_lsu_if.slave  bus,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
  typedef enum logic [1:0] {K_LW, K_LBU, K_SW, K_SB} kind_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [1:0]  boff_q, boff_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] ea;
  kind_e       acc_kind;
  logic        acc_none;
  logic        acc_misaligned;
  logic        in_ready_w;

  assign in_ready_w = (state_q == S_IDLE) && !rst;

  // Decode with priority lw > lbu > sw > sb; no bit set means no access.
  always_comb begin
    ea       = bus.in_rs1 + bus.in_imm;
    acc_kind = K_LW;
    acc_none = 1'b0;
    if (bus.in_op[0])      acc_kind = K_LW;
    else if (bus.in_op[1]) acc_kind = K_LBU;
    else if (bus.in_op[2]) acc_kind = K_SW;
    else if (bus.in_op[3]) acc_kind = K_SB;
    else                   acc_none = 1'b1;
    acc_misaligned = !acc_none && (acc_kind == K_LW || acc_kind == K_SW) && (ea[1:0] != 2'b00);
  end

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    boff_d      = boff_q;
    cnt_d       = cnt_q;
    req_valid_d = req_valid_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    out_valid_d = out_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_w) begin
          kind_d = acc_kind;
          boff_d = ea[1:0];
          if (acc_none || acc_misaligned) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            rdata_d     = 32'h0;
            err_d       = acc_misaligned;
          end else begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            addr_d      = {ea[31:2], 2'b00};
            wen_d       = (acc_kind == K_SW) || (acc_kind == K_SB);
            wdata_d     = 32'h0;
            wmask_d     = 4'b0000;
            if (acc_kind == K_SW) begin
              wdata_d = bus.in_rs2;
              wmask_d = 4'b1111;
            end else if (acc_kind == K_SB) begin
              wdata_d = {4{bus.in_rs2[7:0]}};
              wmask_d = 4'b0001 << ea[1:0];
            end
          end
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) begin
          req_valid_d = 1'b0;
          cnt_d       = 16'd0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response arriving in the last allowed cycle still wins over the timeout.
        if (bus.mem_resp_valid) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          err_d       = 1'b0;
          case (kind_q)
            K_LW:    rdata_d = bus.mem_rdata;
            K_LBU:   rdata_d = {24'h0, bus.mem_rdata[{boff_q, 3'b000} +: 8]};
            default: rdata_d = 32'h0;
          endcase
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          err_d       = 1'b1;
          rdata_d     = 32'h0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      kind_q      <= K_LW;
      boff_q      <= 2'b00;
      cnt_q       <= 16'd0;
      req_valid_q <= 1'b0;
      addr_q      <= 32'h0;
      wen_q       <= 1'b0;
      wdata_q     <= 32'h0;
      wmask_q     <= 4'b0000;
      out_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      boff_q      <= boff_d;
      cnt_q       <= cnt_d;
      req_valid_q <= req_valid_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      out_valid_q <= out_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready      = in_ready_w;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_rdata     = rdata_q;
  assign bus.out_err       = err_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Directed bench for the load/store unit: drivers push hand-computed expectations,
// two negedge monitors compare memory requests and completions against them.
module tb_ysyx_25020047_lsu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  ysyx_25020047_lsu_if bus();

  ysyx_25020047_lsu #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;
  int accept_cyc = 0;

  // {addr, wen, wdata, wmask} and {latency (FF = skip), err, rdata}
  logic [68:0] req_q[$];
  logic [40:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_req(input logic [31:0] addr, input logic wen, input logic [31:0] wdata, input logic [3:0] mask);
    req_q.push_back({addr, wen, wdata, mask});
  endtask

  task automatic push_exp(input logic [7:0] lat, input logic err, input logic [31:0] rdata);
    exp_q.push_back({lat, err, rdata});
  endtask

  // Request monitor: every cycle a request is presented it must match the head entry.
  always @(negedge clk) begin
    logic [68:0] r;
    if (!rst && bus.mem_req_valid) begin
      if (req_q.size() == 0) check("req_unexpected", 64'(bus.mem_req_valid), 64'd0);
      else begin
        r = req_q[0];
        check("mem_addr", 64'(bus.mem_addr), 64'(r[68:37]));
        check("mem_wen", 64'(bus.mem_wen), 64'(r[36]));
        check("mem_wmask", 64'(bus.mem_wmask), 64'(r[3:0]));
        if (r[36]) check("mem_wdata", 64'(bus.mem_wdata), 64'(r[35:4]));
        if (bus.mem_req_ready) void'(req_q.pop_front());
      end
    end
  end

  // Completion monitor: latency on the rising edge of out_valid, payload every held cycle.
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    logic [40:0] e;
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) check("out_unexpected", 64'(bus.out_valid), 64'd0);
      else begin
        e = exp_q[0];
        if (!ov_prev && e[40:33] != 8'hFF) check("out_latency", 64'(cyc - accept_cyc), 64'(e[40:33]));
        check("out_rdata", 64'(bus.out_rdata), 64'(e[31:0]));
        check("out_err", 64'(bus.out_err), 64'(e[32]));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
    ov_prev = bus.out_valid;
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
    @(posedge clk); #1;
    accept_cyc   = cyc;
    bus.in_valid = 1'b0;
    bus.in_op    = 4'b0000;
  endtask

  task automatic serve(input int rdy_dly, input bit respond, input logic [31:0] rdata, input int resp_dly);
    int n = 0;
    while (!bus.mem_req_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.mem_req_valid) check("req_timeout", 64'(bus.mem_req_valid), 64'd1);
    else begin
      repeat (rdy_dly) begin @(posedge clk); #1; end
      bus.mem_req_ready = 1'b1;
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b0;
      if (respond) begin
        repeat (resp_dly) begin @(posedge clk); #1; end
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = rdata;
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b0;
      end
    end
  endtask

  task automatic finish_op(input int hold);
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.out_valid) check("out_timeout", 64'(bus.out_valid), 64'd1);
    repeat (hold) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                     input bit mem, input int rdy_dly, input bit respond, input logic [31:0] rdata,
                     input int resp_dly, input int hold);
    bus.out_ready = (hold == 0);
    issue(op, rs1, rs2, imm);
    if (mem) serve(rdy_dly, respond, rdata, resp_dly);
    finish_op(hold);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
    check({tag, "_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
    check({tag, "_addr"}, 64'(bus.mem_addr), 64'd0);
    check({tag, "_wen"}, 64'(bus.mem_wen), 64'd0);
    check({tag, "_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check({tag, "_wmask"}, 64'(bus.mem_wmask), 64'd0);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_rdata"}, 64'(bus.out_rdata), 64'd0);
    check({tag, "_out_err"}, 64'(bus.out_err), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.in_valid       = 1'b0;
    bus.in_op          = 4'b0000;
    bus.in_rs1         = 32'h0;
    bus.in_rs2         = 32'h0;
    bus.in_imm         = 32'h0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = 32'h0;
    bus.out_ready      = 1'b1;

    // Clock/reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    #1 check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    // lw best case
    push_req(32'h80000010, 1'b0, 32'h0, 4'b0000);
    push_exp(8'd2, 1'b0, 32'hDEADBEEF);
    run(4'b0001, 32'h80000000, 32'h0, 32'h10, 1, 0, 1, 32'hDEADBEEF, 0, 0);

    // lbu top byte, then wrap-around negative immediate
    push_req(32'h80000000, 1'b0, 32'h0, 4'b0000);
    push_exp(8'd2, 1'b0, 32'h000000A1);
    run(4'b0010, 32'h80000003, 32'h0, 32'h0, 1, 0, 1, 32'hA1B2C3D4, 0, 0);
    push_req(32'h80000000, 1'b0, 32'h0, 4'b0000);
    push_exp(8'd2, 1'b0, 32'h000000D4);
    run(4'b0010, 32'h80000003, 32'h0, 32'hFFFFFFFD, 1, 0, 1, 32'hA1B2C3D4, 0, 0);

    // sb lane 2 and lane 3, sw full word
    push_req(32'h80000100, 1'b1, 32'hABABABAB, 4'b0100);
    push_exp(8'd2, 1'b0, 32'h0);
    run(4'b1000, 32'h80000100, 32'h123456AB, 32'h2, 1, 0, 1, 32'hFFFFFFFF, 0, 0);
    push_req(32'h00000010, 1'b1, 32'hC5C5C5C5, 4'b1000);
    push_exp(8'd2, 1'b0, 32'h0);
    run(4'b1000, 32'h00000010, 32'h000000C5, 32'h3, 1, 0, 1, 32'h0, 0, 0);
    push_req(32'h80000204, 1'b1, 32'hCAFEF00D, 4'b1111);
    push_exp(8'd2, 1'b0, 32'h0);
    run(4'b0100, 32'h80000200, 32'hCAFEF00D, 32'h4, 1, 0, 1, 32'h12345678, 0, 0);

    // Misaligned lw/sw and empty op complete without a memory access
    push_exp(8'd0, 1'b1, 32'h0);
    run(4'b0001, 32'h80000000, 32'h0, 32'h2, 0, 0, 0, 32'h0, 0, 0);
    push_exp(8'd0, 1'b1, 32'h0);
    run(4'b0100, 32'h80000001, 32'h55555555, 32'h0, 0, 0, 0, 32'h0, 0, 0);
    push_exp(8'd0, 1'b0, 32'h0);
    run(4'b0000, 32'h80000000, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 0);

    // Multi-hot ops resolve by priority
    push_req(32'h80000000, 1'b0, 32'h0, 4'b0000);
    push_exp(8'd2, 1'b0, 32'h00000033);
    run(4'b1010, 32'h80000001, 32'h0, 32'h0, 1, 0, 1, 32'h11223344, 0, 0);
    push_req(32'h80000004, 1'b0, 32'h0, 4'b0000);
    push_exp(8'd2, 1'b0, 32'h55AA55AA);
    run(4'b1111, 32'h80000004, 32'h0, 32'h0, 1, 0, 1, 32'h55AA55AA, 0, 0);

    // Stalled request (5 cycles) and stalled writeback (5 cycles)
    push_req(32'h8000001C, 1'b1, 32'h0BADF00D, 4'b1111);
    push_exp(8'd7, 1'b0, 32'h0);
    run(4'b0100, 32'h80000020, 32'h0BADF00D, 32'hFFFFFFFC, 1, 5, 1, 32'h0, 0, 5);

    // Response delayed two cycles, still inside the watchdog window
    push_req(32'h80000080, 1'b0, 32'h0, 4'b0000);
    push_exp(8'd4, 1'b0, 32'h0F0F0F0F);
    run(4'b0001, 32'h80000080, 32'h0, 32'h0, 1, 0, 1, 32'h0F0F0F0F, 2, 0);

    // Timeout after 4 silent WAIT cycles, then a stray response in IDLE
    push_req(32'h80000040, 1'b0, 32'h0, 4'b0000);
    push_exp(8'd5, 1'b1, 32'h0);
    run(4'b0001, 32'h80000040, 32'h0, 32'h0, 1, 0, 0, 32'h0, 0, 0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hBAADBAAD;
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    check("stray_resp_state", 64'(dbg_state), 64'd0);
    check("stray_resp_out_valid", 64'(bus.out_valid), 64'd0);
    check("stray_resp_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    // Reset while waiting for a response abandons the op silently
    push_req(32'h80000100, 1'b0, 32'h0, 4'b0000);
    bus.out_ready = 1'b1;
    issue(4'b0001, 32'h80000100, 32'h0, 32'h0);
    serve(0, 0, 32'h0, 0);
    @(posedge clk); #1;
    check("pre_reset_state_wait", 64'(dbg_state), 64'd2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_quiet("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    #1 check("in_ready_after_mid_reset", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    push_req(32'h80000300, 1'b0, 32'h0, 4'b0000);
    push_exp(8'd2, 1'b0, 32'h76543210);
    run(4'b0001, 32'h80000300, 32'h0, 32'h0, 1, 0, 1, 32'h76543210, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("req_queue_drained", 64'(req_q.size()), 64'd0);
    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
